// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for bus_arbiter: FSM state encoding, default widths and reset level.
// The ARB_FAIR_EN macro (see bus_arbiter.sv) selects alternating arbitration.
`ifndef BUS_ARBITER_DEFINES
`define BUS_ARBITER_DEFINES
`define RstEnable 1'b0
`endif

package bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic RST_ENABLE = `RstEnable;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INST = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates fetch and data requests onto one registered memory port.
// Define ARB_FAIR_EN to alternate grants on contention; otherwise data always wins.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_be,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_valid,
    input  logic                flush_i,
    output logic                stop_from_if,
    output logic                stop_from_mem,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ready,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              discard_q, discard_d;
    logic              grant_ok;
    logic              pick_inst;

    // Requesters only update their request after seeing a valid pulse, so hold off a cycle.
    assign grant_ok = ~(if_valid_q | mem_valid_q);

`ifdef ARB_FAIR_EN
    logic last_data_q, last_data_d;
    assign pick_inst = if_req & ~flush_i & (~mem_req | last_data_q);
`else
    assign pick_inst = if_req & ~flush_i & ~mem_req;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        discard_d   = discard_q;
`ifdef ARB_FAIR_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                if (grant_ok && pick_inst) begin
                    state_d     = ST_INST;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
`ifdef ARB_FAIR_EN
                    last_data_d = 1'b0;
`endif
                end else if (grant_ok && mem_req) begin
                    state_d     = ST_DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_be_d    = mem_be;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
`ifdef ARB_FAIR_EN
                    last_data_d = 1'b1;
`endif
                end
            end
            ST_INST: begin
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (bus_ready) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    discard_d = 1'b0;
                    // A flushed or abandoned fetch still finishes on the bus but is not delivered.
                    if (if_req && !discard_q && !flush_i) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end
            end
            ST_DATA: begin
                if (bus_ready) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    if (mem_req) begin
                        mem_valid_d = 1'b1;
                        if (!bus_we_q) begin
                            mem_rdata_d = bus_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            discard_q   <= 1'b0;
`ifdef ARB_FAIR_EN
            last_data_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            discard_q   <= discard_d;
`ifdef ARB_FAIR_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    assign bus_req       = bus_req_q;
    assign bus_we        = bus_we_q;
    assign bus_be        = bus_be_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign if_valid      = if_valid_q;
    assign mem_valid     = mem_valid_q;
    assign if_rdata      = if_rdata_q;
    assign mem_rdata     = mem_rdata_q;
    assign stop_from_if  = if_req & ~if_valid_q;
    assign stop_from_mem = mem_req & ~mem_valid_q;

endmodule
